divide: RTL and testbench
=========================

DIVIDE -- requirements
Module: divide

Interface
REQ-001 SHALL have parameter: WIDTH, default 8, operand/quotient/remainder width in bits (WIDTH >= 2).
REQ-002 SHALL have ports: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have ports: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: start  input  1  request to begin a division.
REQ-005 SHALL have ports: dividend  input  WIDTH  unsigned numerator.
REQ-006 SHALL have ports: divisor  input  WIDTH  unsigned denominator.
REQ-007 SHALL have ports: ready  output  1  high when idle and able to accept start.
REQ-008 SHALL have ports: done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL have ports: quotient  output  WIDTH  registered unsigned quotient.
REQ-010 SHALL have ports: remainder  output  WIDTH  registered unsigned remainder.
REQ-011 SHALL have ports: divByZero  output  1  registered flag, divisor was zero.

Function
REQ-012 SHALL implement an iterative restoring unsigned divider producing one quotient bit per clock, MSB first.
REQ-013 SHALL use a three-state FSM: IDLE, RUN, DONE.
REQ-014 SHALL accept a request only on a rising edge where start=1 and ready=1; dividend and divisor are captured on that edge, and later input changes have no effect on the operation.
REQ-015 SHALL drive ready=1 only in IDLE; start while in RUN or DONE is ignored (no queuing).
REQ-016 SHALL, on acceptance with divisor!=0, move IDLE->RUN and clear the internal partial remainder to 0 and the bit counter to WIDTH-1.
REQ-017 SHALL, on each RUN edge, shift partial remainder left by one and bring in the next dividend bit (WIDTH+1-bit working width to avoid overflow), subtract divisor, keep the difference and set the quotient bit to 1 if non-negative, else restore and set 0.
REQ-018 SHALL perform exactly WIDTH RUN steps, then move RUN->DONE; done is high for exactly the one cycle in DONE, i.e. from the WIDTH-th edge after the accepting edge.
REQ-019 SHALL move DONE->IDLE unconditionally on the next edge (ready rises one cycle after done).
REQ-020 SHALL, on acceptance with divisor==0, move IDLE->DONE directly (done one edge after the accepting edge) with quotient = all ones, remainder = dividend, divByZero=1.
REQ-021 SHALL set divByZero=0 for every non-zero-divisor result.
REQ-022 SHALL update quotient, remainder, divByZero only when entering DONE; they hold their values through IDLE until the next result (not cleared by a new accept).
REQ-023 SHALL guarantee dividend = quotient*divisor + remainder and remainder < divisor for all divisor!=0, over the full 0..2^WIDTH-1 range of both operands.
REQ-024 SHALL not pipeline or overlap operations; throughput is one result per WIDTH+2 cycles when start is held high.

Reset
REQ-025 SHALL, on any edge with reset=1, go to IDLE and set ready=1, done=0, quotient=0, remainder=0, divByZero=0, regardless of state.
REQ-026 SHALL treat reset mid-RUN as an abort: no done pulse for the aborted operation, and reset has priority over start on the same edge.

Verification
REQ-027 SHALL verify (WIDTH=8): accept 100/7 -> done exactly 8 edges after accept, quotient=14, remainder=2, divByZero=0.
REQ-028 SHALL verify boundaries: 255/1 -> 255 r0; 5/9 -> 0 r5; 0/3 -> 0 r0; 255/255 -> 1 r0.
REQ-029 SHALL verify 37/0 -> done 1 edge after accept, quotient=255, remainder=37, divByZero=1; a following 10/3 -> 3 r1, divByZero=0.
REQ-030 SHALL verify start held high continuously with changing operands: only operands present at each ready=1 edge are used, results every 10 cycles, inputs changed during RUN ignored.
REQ-031 SHALL verify reset asserted on the 4th RUN edge of 200/3: no done, all outputs 0, ready=1 next cycle; subsequent 200/3 -> 66 r2.
REQ-032 SHALL verify randomized exhaustive-style sweep against a reference model checking REQ-023 and latency on every result.

Source files
------------

// File: rtl/divide.sv
// divide: iterative restoring unsigned divider, one quotient bit per clock, MSB first.
module divide #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             divByZero
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} stateType;
    stateType state, nextState;
    logic [WIDTH-1:0] partRem, work, dsr, newRem;
    logic [WIDTH:0] shifted;
    logic [CW-1:0] count;
    logic accept, fit;
    assign accept = start && state == IDLE;
    assign shifted = {partRem, work[WIDTH-1]};
    assign fit = shifted >= {1'b0, dsr};
    assign newRem = WIDTH'(fit ? shifted - {1'b0, dsr} : shifted);
    always_ff @(posedge clk)
        state <= reset ? IDLE : nextState;
    always_comb begin
        nextState = state == IDLE ? (start ? (divisor == '0 ? DONE : RUN) : IDLE)
                  : state == RUN  ? (count == '0 ? DONE : RUN) : IDLE;
        ready = state == IDLE;
        done = state == DONE;
    end
    // work holds the unconsumed dividend bits at the top and the quotient bits filling in from the bottom
    always_ff @(posedge clk) begin
        if (reset) begin
            partRem <= '0;
            work <= '0;
            dsr <= '0;
            count <= '0;
            quotient <= '0;
            remainder <= '0;
            divByZero <= 1'b0;
        end else if (accept) begin
            partRem <= '0;
            work <= dividend;
            dsr <= divisor;
            count <= CW'(WIDTH - 1);
            if (divisor == '0) begin
                quotient <= '1;
                remainder <= dividend;
                divByZero <= 1'b1;
            end
        end else if (state == RUN) begin
            partRem <= newRem;
            work <= {work[WIDTH-2:0], fit};
            count <= count - 1'b1;
            if (count == '0) begin
                quotient <= {work[WIDTH-2:0], fit};
                remainder <= newRem;
                divByZero <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_divide.sv
// tb_divide: directed and randomized checks of the 8-bit iterative divider.
module tb_divide;
    logic clk = 1'b0;
    logic reset, start;
    logic [7:0] dividend, divisor, quotient, remainder;
    logic ready, done, divByZero;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] prevQ, prevR;
    logic prevZ;

    divide #(.WIDTH(8)) dut (
        .clk(clk), .reset(reset), .start(start), .dividend(dividend), .divisor(divisor),
        .ready(ready), .done(done), .quotient(quotient), .remainder(remainder), .divByZero(divByZero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic waitDone(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // A zero divisor skips RUN, so done is already high just after the accepting edge.
    task automatic runDiv(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] eq, er;
        logic ez;
        int n;
        ez = b == 8'd0;
        eq = ez ? 8'hff : a / b;
        er = ez ? a : a % b;
        @(negedge clk);
        check("ready_before", ready, 1);
        dividend = a;
        divisor = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dividend = ~a;
        divisor = b + 8'd1;
        if (!ez) check("hold_on_accept", quotient, prevQ);
        waitDone(n);
        check("latency", n, ez ? 0 : 8);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("divByZero", divByZero, ez);
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("ready_after", ready, 1);
        check("hold_idle", quotient, eq);
        prevQ = eq;
        prevR = er;
        prevZ = ez;
    endtask

    initial begin
        logic [7:0] va [4] = '{8'd50, 8'd255, 8'd9, 8'd0};
        logic [7:0] vb [4] = '{8'd6, 8'd16, 8'd200, 8'd1};
        logic [7:0] vq [3] = '{8'd8, 8'd15, 8'd0};
        logic [7:0] vr [3] = '{8'd2, 8'd15, 8'd9};
        int n, lastDone;
        logic sawDone;
        reset = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ready", ready, 1);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_divByZero", divByZero, 0);
        prevQ = 0;
        prevR = 0;
        prevZ = 0;

        runDiv(8'd100, 8'd7);
        check("q_100_7", quotient, 14);
        runDiv(8'd255, 8'd1);
        runDiv(8'd5, 8'd9);
        runDiv(8'd0, 8'd3);
        runDiv(8'd255, 8'd255);
        check("q_255_255", quotient, 1);
        runDiv(8'd37, 8'd0);
        check("r_37_0", remainder, 37);
        runDiv(8'd10, 8'd3);
        check("q_10_3", quotient, 3);

        // start held high; operands are scrambled while the divider is busy
        @(negedge clk);
        dividend = va[0];
        divisor = vb[0];
        start = 1'b1;
        lastDone = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("held_accepted", ready, 0);
            dividend = 8'hAA ^ 8'(k);
            divisor = 8'd0;
            waitDone(n);
            check("held_latency", n, 8);
            check("held_quotient", quotient, vq[k]);
            check("held_remainder", remainder, vr[k]);
            check("held_divByZero", divByZero, 0);
            if (k > 0) check("held_period", cyc - lastDone, 10);
            lastDone = cyc;
            dividend = va[k+1];
            divisor = vb[k+1];
            if (k == 2) start = 1'b0;
            @(posedge clk);
            #1;
            check("held_ready", ready, 1);
        end
        prevQ = 0;
        prevR = 9;
        prevZ = 0;

        // reset lands on the 4th RUN edge, together with start
        @(negedge clk);
        dividend = 8'd200;
        divisor = 8'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        check("abort_ready", ready, 1);
        check("abort_done", done, 0);
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 9'd0);
        check("abort_divByZero", divByZero, 0);
        sawDone = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        check("abort_no_done", sawDone, 0);
        prevQ = 0;
        prevR = 0;
        prevZ = 0;
        runDiv(8'd200, 8'd3);
        check("q_200_3", quotient, 66);
        check("r_200_3", remainder, 2);

        for (int i = 0; i < 60; i++)
            runDiv(8'($urandom_range(255)), (i % 8 == 7) ? 8'd0 : 8'($urandom_range(255, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
